// File: rtl/fpu_io_loader_if.sv
// Bus bundle between the operand loader and its neighbours: the 5-bit beat
// streams in both directions plus the registered operand/result lines of the FPU.
interface fpu_io_loader_if;
    logic [4:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] fpu_a;
    logic [9:0] fpu_b;
    logic [3:0] fpu_sel;
    logic [9:0] fpu_y;
    logic [4:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       abort;

    modport slave (
        input  in_data, in_valid, fpu_y, out_ready,
        output in_ready, fpu_a, fpu_b, fpu_sel, out_data, out_valid, abort
    );

    modport master (
        output in_data, in_valid, fpu_y, out_ready,
        input  in_ready, fpu_a, fpu_b, fpu_sel, out_data, out_valid, abort
    );
endinterface

// File: rtl/fpu_io_loader.sv
// Loads opcode and two 10-bit operands as five 5-bit beats, runs the combinational
// FPU for one cycle, then returns the 10-bit result as two 5-bit beats.
module fpu_io_loader #(
    parameter int unsigned ABORT_TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset,
    fpu_io_loader_if.slave bus
);
    localparam logic [7:0] TIMEOUT_LIM = 8'(ABORT_TIMEOUT);
    localparam bit         TIMEOUT_EN  = (ABORT_TIMEOUT != 0);

    typedef enum logic [2:0] {
        LD_SEL, LD_A0, LD_A1, LD_B0, LD_B1, EXEC, TX_LO, TX_HI
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [9:0] a_q, a_d;
    logic [9:0] b_q, b_d;
    logic [9:0] y_q, y_d;
    logic [7:0] idle_q, idle_d;
    logic       abort_q, abort_d;

    logic       loading;
    logic       partial;
    logic       timeout;
    logic       in_fire;
    logic       out_fire;
    logic       tx;

    always_comb begin
        loading = 1'b0;
        partial = 1'b0;
        tx      = 1'b0;
        case (state_q)
            LD_SEL:                     loading = 1'b1;
            LD_A0, LD_A1, LD_B0, LD_B1: begin
                loading = 1'b1;
                partial = 1'b1;
            end
            TX_LO, TX_HI:               tx = 1'b1;
            default:                    ;
        endcase
    end

    // Timeout wins over a beat offered in the same cycle.
    assign timeout  = TIMEOUT_EN && partial && (idle_q == TIMEOUT_LIM);
    assign in_fire  = bus.in_valid && loading && !timeout;
    assign out_fire = bus.out_ready && tx;

    assign bus.in_ready  = loading;
    assign bus.out_valid = tx;
    assign bus.fpu_a     = a_q;
    assign bus.fpu_b     = b_q;
    assign bus.fpu_sel   = sel_q;
    assign bus.abort     = abort_q;

    always_comb begin
        bus.out_data = 5'd0;
        if (state_q == TX_LO) begin
            bus.out_data = y_q[4:0];
        end else if (state_q == TX_HI) begin
            bus.out_data = y_q[9:5];
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        idle_d  = idle_q;
        abort_d = 1'b0;

        if (timeout) begin
            // Partial operand contents are deliberately left in place.
            state_d = LD_SEL;
            idle_d  = 8'd0;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                LD_SEL: begin
                    if (in_fire) begin
                        sel_d   = bus.in_data[3:0];
                        idle_d  = 8'd0;
                        state_d = LD_A0;
                    end
                end
                LD_A0: begin
                    if (in_fire) begin
                        a_d[4:0] = bus.in_data;
                        state_d  = LD_A1;
                    end
                end
                LD_A1: begin
                    if (in_fire) begin
                        a_d[9:5] = bus.in_data;
                        state_d  = LD_B0;
                    end
                end
                LD_B0: begin
                    if (in_fire) begin
                        b_d[4:0] = bus.in_data;
                        state_d  = LD_B1;
                    end
                end
                LD_B1: begin
                    if (in_fire) begin
                        b_d[9:5] = bus.in_data;
                        state_d  = EXEC;
                    end
                end
                EXEC: begin
                    y_d     = bus.fpu_y;
                    state_d = TX_LO;
                end
                TX_LO: begin
                    if (out_fire) begin
                        state_d = TX_HI;
                    end
                end
                TX_HI: begin
                    if (out_fire) begin
                        state_d = LD_SEL;
                        idle_d  = 8'd0;
                    end
                end
                default: state_d = LD_SEL;
            endcase

            if (partial) begin
                if (in_fire) begin
                    idle_d = 8'd0;
                end else if (idle_q != 8'hFF) begin
                    idle_d = idle_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LD_SEL;
            sel_q   <= 4'd0;
            a_q     <= 10'd0;
            b_q     <= 10'd0;
            y_q     <= 10'd0;
            idle_q  <= 8'd0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            idle_q  <= idle_d;
            abort_q <= abort_d;
        end
    end
endmodule
